sram_rw_port_master: RTL

//  Initiator for the RW port (port 0) of the 32x512 OpenRAM macro. Accepts read/write requests
//  on a valid/ready stream and drives csb0/web0/wmask0/addr0/din0 from registers. Captures dout0
//  and returns read data, in order, on a valid/ready response stream. Sits between core logic
//  and the SRAM macro. Credit-based flow control means no read data is ever dropped.

---
 rtl/sram_pkg.sv | 16 +
 rtl/sram_rsp_fifo.sv | 61 ++++++
 rtl/sram_rw_port_master.sv | 97 +++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared SRAM port constants and request bundle.
// Geometry matches the 32x512 single-RW-port macro.
package sram_pkg;

   localparam int SRAM_ADDR_W     = 9;
   localparam int SRAM_DATA_W     = 32;
   localparam int SRAM_NUM_WMASKS = SRAM_DATA_W / 8;

   typedef struct packed {
      logic                       we;
      logic [SRAM_ADDR_W-1:0]     addr;
      logic [SRAM_DATA_W-1:0]     wdata;
      logic [SRAM_NUM_WMASKS-1:0] wmask;
   } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// In-order read-data buffer for the SRAM port master.
// Head entry is presented directly; push and pop may coincide.
import sram_pkg::*;

module sram_rsp_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = SRAM_DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             not_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             full;
   logic             do_pop;

   assign not_empty = (count != '0);
   assign full      = (count == CW'(DEPTH));
   assign do_pop    = pop & not_empty;
   assign head      = mem[rd_ptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_no_overflow: assert property (
      @(posedge clk) disable iff (!rst_n) !(push && full && !do_pop)
   );

endmodule

// File: rtl/sram_rw_port_master.sv
// Initiator for the RW port of the 32x512 SRAM macro.
// Credits cover the tag pipeline plus buffer, so read data is never dropped.
import sram_pkg::*;

module sram_rw_port_master #(
   parameter int ADDR_WIDTH = SRAM_ADDR_W,
   parameter int DATA_WIDTH = SRAM_DATA_W,
   parameter int NUM_WMASKS = SRAM_NUM_WMASKS,
   parameter int RSP_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [NUM_WMASKS-1:0] req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int CW = $clog2(RSP_DEPTH + 1);

   logic [CW-1:0] credits;
   logic [1:0]    rd_tag;
   logic          req_hs;
   logic          rd_hs;
   logic          rsp_hs;

   assign req_ready = (credits != '0) | ~(req_valid & ~req_we);
   assign req_hs    = req_valid & req_ready;
   assign rd_hs     = req_hs & ~req_we;
   assign rsp_hs    = rsp_valid & rsp_ready;

   // SRAM pin registers; select only on an accepted request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= '0;
         sram_addr0  <= '0;
         sram_din0   <= '0;
      end else begin
         sram_csb0 <= ~req_hs;
         sram_web0 <= ~(req_hs & req_we);
         if (req_hs) begin
            sram_addr0  <= req_addr;
            sram_din0   <= req_wdata;
            sram_wmask0 <= req_we ? req_wmask : '0;
         end
      end
   end

   // Read tag: stage 0 = pins presented, stage 1 = SRAM sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_tag <= '0;
      end else begin
         rd_tag <= {rd_tag[0], rd_hs};
      end
   end

   // Credits: reads in flight plus buffered may not exceed buffer depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits <= CW'(RSP_DEPTH);
      end else begin
         case ({rd_hs, rsp_hs})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   sram_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (rd_tag[1]),
      .push_data (sram_dout0),
      .pop       (rsp_ready),
      .head      (rsp_rdata),
      .not_empty (rsp_valid)
   );

endmodule
